// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write-side pointer engine.
// Holds the default pointer geometry and the Gray/binary conversion helpers.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int PTR_W          = ADDR_WIDTH_DEF + 1;

  // Helpers operate on a wide word; callers size-cast to their pointer width.
  // Zero-extension is harmless for both conversions.
  localparam int FN_W = 32;

  function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    for (int i = 0; i < FN_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO: producer request, synchronized read
// pointer and overflow clear in; pointer, RAM strobe/address and status out.
// master = producer / surrounding logic, slave = fifo_wptr_full.
interface fifo_wptr_full_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

  localparam int PW = ADDR_WIDTH + 1;

  logic                  wr_en;
  logic [PW-1:0]         rptr_gray_syn;
  logic                  ovf_clr;
  logic [PW-1:0]         wr_ptr_gray;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_inc;
  logic                  full;
  logic                  almost_full;
  logic [PW-1:0]         wr_level;
  logic                  overflow;

  modport master (
    output wr_en, rptr_gray_syn, ovf_clr,
    input  wr_ptr_gray, wr_addr, wr_inc, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, rptr_gray_syn, ovf_clr,
    output wr_ptr_gray, wr_addr, wr_inc, full, almost_full, wr_level, overflow
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray -> binary converter. Each binary bit is the XOR of the
// Gray bit at that position and every bit above it.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // XOR prefix from the MSB down; written as a reduction per bit so no bit of
  // bin depends on another bit of bin.
  always_comb begin
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag engine of the async FIFO.
// Keeps the binary write pointer, launches a registered Gray pointer to the
// read domain, and derives full / level / overflow from the read Gray pointer
// already synchronized into wr_clk.
// Optional feature: define WPTR_ALMOST_FULL_EN to build the almost_full
// comparator (level >= AF_THRESH); otherwise almost_full is tied low.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_THRESH  = 12
) (
  input  logic             wr_clk,
  input  logic             rst,
  fifo_wptr_full_if.slave  bus
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Reject illegal geometries at elaboration time.
  if (ADDR_WIDTH < 2) begin : g_bad_addr_width
    $error("fifo_wptr_full: ADDR_WIDTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
    $error("fifo_wptr_full: AF_THRESH must be in 1..2**ADDR_WIDTH");
  end

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wgray_q;
  logic          full_q;
  logic [PW-1:0] level_q;
  logic          overflow_q;

  logic          accept;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_pat;
  logic [PW-1:0] level_next;

  fifo_gray2bin #(.W(PW)) u_rptr_gray2bin (
    .gray (bus.rptr_gray_syn),
    .bin  (rbin)
  );

  // The RAM strobe is also held off during reset so nothing is written while
  // the pointers are being cleared.
  assign accept = bus.wr_en & ~full_q & ~rst;

  // Next-pointer arithmetic; full compares the next Gray pointer with the read
  // pointer's top two bits inverted (write has lapped read by one full depth).
  // NOTE: every signal driven here gets an assignment on every path, otherwise
  // the tool infers a latch to hold the old value.
  always_comb begin
    wbin_next  = wbin_q + PW'(accept);
    gray_next  = PW'(bin2gray(FN_W'(wbin_next)));
    full_pat   = {~bus.rptr_gray_syn[PW-1:PW-2], bus.rptr_gray_syn[PW-3:0]};
    level_next = wbin_next - rbin;
  end

  // Pointer and status registers; overflow is sticky and a new set wins over
  // a simultaneous clear.
  // NOTE: non-blocking assignments here so every register samples the values
  // from before this edge, regardless of statement order.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      full_q     <= 1'b0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wbin_q     <= wbin_next;
      wgray_q    <= gray_next;
      full_q     <= (gray_next == full_pat);
      level_q    <= level_next;
      overflow_q <= (bus.wr_en & full_q) | (overflow_q & ~bus.ovf_clr);
    end
  end

`ifdef WPTR_ALMOST_FULL_EN
  logic af_q;

  // Almost-full looks at the next level so it lines up with wr_level.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (level_next >= PW'(AF_THRESH));
    end
  end

  assign bus.almost_full = af_q;
`else
  assign bus.almost_full = 1'b0;
`endif

  assign bus.wr_inc      = accept;
  assign bus.wr_addr     = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wr_ptr_gray = wgray_q;
  assign bus.full        = full_q;
  assign bus.wr_level    = level_q;
  assign bus.overflow    = overflow_q;

endmodule
